// File: rtl/jk_pkg.sv
// ---------------------------------------------------------------------------
// jk_pkg
// Shared definitions for the JK command sequencer:
//   - command op encoding (what the sequencer drives onto J/K)
//   - FSM state encoding (also visible on the sequencer debug port)
//   - expected_q(): the value a JK flip-flop holds after one clock with the
//     given op applied, starting from q.
// ---------------------------------------------------------------------------
package jk_pkg;

  typedef logic [1:0] jk_op_t;
  typedef logic [1:0] jk_state_t;

  // Op encoding is chosen so that op[1] is J and op[0] is K.
  localparam jk_op_t OP_HOLD   = 2'b00;
  localparam jk_op_t OP_RESET  = 2'b01;
  localparam jk_op_t OP_SET    = 2'b10;
  localparam jk_op_t OP_TOGGLE = 2'b11;

  localparam jk_state_t ST_IDLE  = 2'd0;
  localparam jk_state_t ST_DRIVE = 2'd1;
  localparam jk_state_t ST_CHECK = 2'd2;

  function automatic logic expected_q(input jk_op_t op, input logic q);
    logic r;
    r = q;
    case (op)
      OP_HOLD:   r = q;
      OP_RESET:  r = 1'b0;
      OP_SET:    r = 1'b1;
      OP_TOGGLE: r = ~q;
      default:   r = q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// ---------------------------------------------------------------------------
// jk_cmd_fifo
// Command FIFO for the JK sequencer. DEPTH entries of 2-bit ops, show-ahead
// read (o_dout is the head entry whenever o_empty=0).
//
// Ports:
//   clk      rising-edge clock
//   i_rst_n  asynchronous active-low reset (pointers/count to 0)
//   i_push   write i_din at the edge (ignored when full unless popping)
//   i_din    2-bit op to write
//   i_pop    remove the head entry at the edge (ignored when empty)
//   o_dout   head entry
//   o_full   count == DEPTH
//   o_empty  count == 0
//   o_count  registered occupancy, 0..DEPTH
//
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// ---------------------------------------------------------------------------
module jk_cmd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [1:0]               i_din,
  input  logic                     i_pop,
  output logic [1:0]               o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [1:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_do_pop;
  logic w_do_push;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // A push into a full FIFO is only safe when the head leaves at the same
  // edge; the new entry then lands in the slot the pop frees.
  assign w_do_pop  = i_pop && !w_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage has no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = r_count;

endmodule

// File: rtl/jk_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// jk_cmd_sequencer
// Queues HOLD/RESET/SET/TOGGLE commands and plays them one at a time onto the
// J/K inputs of a downstream JK flip-flop, then checks the q it returns.
//
// Per command: IDLE/CHECK pops and loads J/K -> DRIVE (one cycle, J/K held,
// expected q captured from the pre-update q_in) -> CHECK (one cycle, done
// pulse, q_in compared against expected). Back-to-back commands alternate
// DRIVE/CHECK, so one command completes every two cycles.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset; drops queued and in-flight work
//   cmd_valid  command offered this cycle
//   cmd_op     00 HOLD, 01 RESET, 10 SET, 11 TOGGLE
//   cmd_ready  FIFO not full (from the registered count)
//   j, k       registered drive to the downstream flip-flop; 00 outside DRIVE
//   q_in       q returned from the downstream flip-flop
//   busy       FSM not IDLE or FIFO not empty
//   done       one-cycle pulse per completed command
//   err        sticky: some checked q_in differed from expected
//   err_clr    synchronous clear of err (a same-edge mismatch wins)
//   stall      when 1 no new command is started; in-flight one completes
//   dbg_state  current FSM state (jk_pkg ST_* encoding)
//   dbg_count  current FIFO occupancy
//
// Command handshake: a command is taken at a rising edge where
// cmd_valid=1 and cmd_ready=1. When cmd_ready=0 the offer is dropped, with
// one exception: if the FSM pops the head at that same edge, the offered
// command fills the freed slot, so the FIFO stays full and cmd_ready stays 0.
// The source never has to hold cmd_valid; nothing is remembered across cycles.
// ---------------------------------------------------------------------------
module jk_cmd_sequencer
  import jk_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  input  logic [1:0]             cmd_op,
  output logic                   cmd_ready,
  output logic                   j,
  output logic                   k,
  input  logic                   q_in,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  input  logic                   err_clr,
  input  logic                   stall,
  output logic [1:0]             dbg_state,
  output logic [$clog2(DEPTH):0] dbg_count
);

  jk_state_t r_state;
  jk_op_t    r_op;
  logic      r_j;
  logic      r_k;
  logic      r_expected;
  logic      r_done;
  logic      r_err;

  logic                   w_full;
  logic                   w_empty;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_mismatch;
  jk_op_t                 w_head;
  logic [$clog2(DEPTH):0] w_count;

  // Only IDLE and CHECK may start a command; DRIVE is always followed by CHECK.
  assign w_pop  = !w_empty && !stall && ((r_state == ST_IDLE) || (r_state == ST_CHECK));
  assign w_push = cmd_valid && (!w_full || w_pop);

  jk_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .i_rst_n (reset),
    .i_push  (w_push),
    .i_din   (cmd_op),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_mismatch = (r_state == ST_CHECK) && (q_in != r_expected);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_op       <= OP_HOLD;
      r_j        <= 1'b0;
      r_k        <= 1'b0;
      r_expected <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_op    <= w_head;
            r_j     <= w_head[1];
            r_k     <= w_head[0];
            r_state <= ST_DRIVE;
          end else begin
            r_j <= 1'b0;
            r_k <= 1'b0;
          end
        end
        ST_DRIVE: begin
          // q_in here is the value before the flip-flop takes this edge.
          r_expected <= expected_q(r_op, q_in);
          r_j        <= 1'b0;
          r_k        <= 1'b0;
          r_state    <= ST_CHECK;
        end
        ST_CHECK: begin
          r_done <= 1'b1;
          if (w_pop) begin
            r_op    <= w_head;
            r_j     <= w_head[1];
            r_k     <= w_head[0];
            r_state <= ST_DRIVE;
          end else begin
            r_j     <= 1'b0;
            r_k     <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_j     <= 1'b0;
          r_k     <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky error; a mismatch at the same edge as err_clr keeps it set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (w_mismatch) begin
      r_err <= 1'b1;
    end else if (err_clr) begin
      r_err <= 1'b0;
    end
  end

  assign cmd_ready = !w_full;
  assign j         = r_j;
  assign k         = r_k;
  assign busy      = (r_state != ST_IDLE) || !w_empty;
  assign done      = r_done;
  assign err       = r_err;
  assign dbg_state = r_state;
  assign dbg_count = w_count;

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
module tb_jk_cmd_sequencer;
  import jk_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          cmd_valid;
  logic [1:0]    cmd_op;
  logic          cmd_ready;
  logic          j;
  logic          k;
  logic          q_in;
  logic          busy;
  logic          done;
  logic          err;
  logic          err_clr;
  logic          stall;
  logic [1:0]    dbg_state;
  logic [CW-1:0] dbg_count;

  // Downstream JK flip-flop model, starts at q=0. force_en pins q_in low.
  logic jk_q = 1'b0;
  logic force_en;
  always @(posedge clk) begin
    case ({j, k})
      2'b01:   jk_q <= 1'b0;
      2'b10:   jk_q <= 1'b1;
      2'b11:   jk_q <= ~jk_q;
      default: jk_q <= jk_q;
    endcase
  end
  assign q_in = force_en ? 1'b0 : jk_q;

  jk_cmd_sequencer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_ready (cmd_ready),
    .j         (j),
    .k         (k),
    .q_in      (q_in),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_clr   (err_clr),
    .stall     (stall),
    .dbg_state (dbg_state),
    .dbg_count (dbg_count)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] op);
    cmd_valid = 1'b1;
    cmd_op    = op;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] st, input int budget, input string tag);
    int n = 0;
    while (dbg_state !== st && n < budget) begin
      tick();
      n++;
    end
    chk(tag, dbg_state, st);
  endtask

  // Run for a fixed number of cycles, checking J/K against exp_q each time
  // the FSM sits in DRIVE, and counting done pulses.
  task automatic drain(input int cycles, output int n_done);
    n_done = 0;
    for (int c = 0; c < cycles; c++) begin
      tick();
      if (done === 1'b1) n_done++;
      if (dbg_state == ST_DRIVE) begin
        if (exp_q.size() == 0) chk("drive_extra", {j, k}, 2'bxx);
        else                   chk("drive_jk", {j, k}, exp_q.pop_front());
      end else begin
        chk("idle_jk_zero", {j, k}, 2'b00);
      end
    end
    chk("drive_left", exp_q.size(), 0);
  endtask

  // Expected trace after edges E1..E10 for SET, TOGGLE, TOGGLE, RESET.
  logic [1:0] t_jk   [10] = '{2'b10, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
  logic       t_done [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [1:0] t_ops  [4]  = '{OP_SET, OP_TOGGLE, OP_TOGGLE, OP_RESET};

  initial begin
    int n_done;

    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = OP_HOLD;
    err_clr   = 1'b0;
    stall     = 1'b0;
    force_en  = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_busy",  busy,      1'b0);
    chk("rst_jk",    {j, k},    2'b00);
    chk("rst_done",  done,      1'b0);
    chk("rst_err",   err,       1'b0);
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_count", dbg_count, 0);

    // Back-to-back SET, TOGGLE, TOGGLE, RESET straight after release
    reset = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      if (c < 4) begin
        cmd_valid = 1'b1;
        cmd_op    = t_ops[c];
      end else begin
        cmd_valid = 1'b0;
      end
      tick();
      if (c == 0) chk("b2b_first_push", dbg_count, 1);
      if (c >= 1) begin
        chk("b2b_jk",   {j, k}, t_jk[c-1]);
        chk("b2b_done", done,   t_done[c-1]);
      end
    end
    chk("b2b_err",  err,  1'b0);
    chk("b2b_busy", busy, 1'b0);

    // Overfill while stalled: DEPTH accepted, the extra one dropped
    stall     = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = OP_SET;    tick(); chk("fill1_ready", cmd_ready, 1'b1);
    cmd_op    = OP_RESET;  tick(); chk("fill2_ready", cmd_ready, 1'b1);
    cmd_op    = OP_TOGGLE; tick(); chk("fill3_ready", cmd_ready, 1'b1);
    cmd_op    = OP_HOLD;   tick(); chk("fill4_ready", cmd_ready, 1'b0);
    chk("fill4_busy", busy, 1'b1);
    cmd_op    = OP_TOGGLE; tick(); chk("fill5_ready", cmd_ready, 1'b0);
    chk("fill5_count", dbg_count, DEPTH);
    cmd_valid = 1'b0;
    stall     = 1'b0;
    exp_q     = '{OP_SET, OP_RESET, OP_TOGGLE, OP_HOLD};
    drain(20, n_done);
    chk("fill_done_cnt", n_done, DEPTH);
    chk("fill_err",      err,    1'b0);
    chk("fill_busy",     busy,   1'b0);

    // Full FIFO: push lands on the same edge as the pop
    stall     = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = OP_RESET; tick();
    cmd_op    = OP_SET;   tick();
    cmd_op    = OP_RESET; tick();
    cmd_op    = OP_SET;   tick();
    chk("full_ready0", cmd_ready, 1'b0);
    stall  = 1'b0;
    cmd_op = OP_TOGGLE;
    tick();
    cmd_valid = 1'b0;
    chk("pp_count", dbg_count, DEPTH);
    chk("pp_ready", cmd_ready, 1'b0);
    chk("pp_jk",    {j, k},    OP_RESET);
    tick();
    chk("pp_count2", dbg_count, DEPTH);
    chk("pp_ready2", cmd_ready, 1'b0);
    exp_q = '{OP_SET, OP_RESET, OP_SET, OP_TOGGLE};
    drain(20, n_done);
    chk("pp_done_cnt", n_done, DEPTH + 1);
    chk("pp_err",      err,    1'b0);

    // Forced mismatch on a SET, then clear priority
    push(OP_SET);
    wait_state(ST_CHECK, 10, "mm1_reach_check");
    force_en = 1'b1;
    tick();
    force_en = 1'b0;
    chk("mm1_err",  err,  1'b1);
    chk("mm1_done", done, 1'b1);
    tick(); tick(); tick();
    chk("mm1_sticky", err, 1'b1);
    push(OP_SET);
    wait_state(ST_CHECK, 10, "mm2_reach_check");
    force_en = 1'b1;
    err_clr  = 1'b1;
    tick();
    force_en = 1'b0;
    err_clr  = 1'b0;
    chk("mm2_err_kept", err, 1'b1);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_err", err, 1'b0);

    // Reset during DRIVE with three commands queued
    stall     = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = OP_SET;    tick();
    cmd_op    = OP_RESET;  tick();
    cmd_op    = OP_TOGGLE; tick();
    cmd_op    = OP_SET;    tick();
    cmd_valid = 1'b0;
    stall     = 1'b0;
    tick();
    chk("mr_in_drive", dbg_state, ST_DRIVE);
    chk("mr_queued",   dbg_count, 3);
    reset = 1'b0;
    #1;
    chk("mr_jk",    {j, k},    2'b00);
    chk("mr_busy",  busy,      1'b0);
    chk("mr_done",  done,      1'b0);
    chk("mr_count", dbg_count, 0);
    chk("mr_ready", cmd_ready, 1'b1);
    tick();
    chk("mr_done_hold", done, 1'b0);
    reset = 1'b1;
    push(OP_HOLD);
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk("hold_jk",   {j, k}, 2'b00);
      chk("hold_done", done,   (c == 3) ? 1'b1 : 1'b0);
    end
    chk("hold_busy", busy, 1'b0);
    chk("hold_err",  err,  1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog: the directed run is a few hundred cycles at most.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/jk_cmd_sequencer.md
JK_CMD_SEQUENCER -- requirements
Module: jk_cmd_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO depth (power of two, >= 2).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 cmd_valid  input  1  command offered this cycle.
REQ-005 cmd_op  input  2  command: 00 HOLD, 01 RESET, 10 SET, 11 TOGGLE.
REQ-006 cmd_ready  output  1  FIFO can accept a command (not full).
REQ-007 j  output  1  registered J drive to the downstream JK flip-flop.
REQ-008 k  output  1  registered K drive to the downstream JK flip-flop.
REQ-009 q_in  input  1  q returned from the downstream JK flip-flop.
REQ-010 busy  output  1  FSM not IDLE or FIFO not empty.
REQ-011 done  output  1  one-cycle pulse per completed command.
REQ-012 err  output  1  sticky flag: some q_in mismatched its expected value.
REQ-013 err_clr  input  1  synchronous clear of err.

Function
REQ-014 Push occurs on a rising edge with cmd_valid=1 and cmd_ready=1; cmd_valid with cmd_ready=0 is ignored (no queueing, no error).
REQ-015 cmd_ready shall equal !full, derived from the registered occupancy count.
REQ-016 Simultaneous push and pop shall leave the count unchanged, including when full.
REQ-017 Commands are executed strictly in FIFO order; pointers wrap modulo DEPTH.
REQ-018 FSM states: IDLE, DRIVE, CHECK.
REQ-019 IDLE: if FIFO is non-empty, pop, load j/k from the op (j=op[1], k=op[0]), go to DRIVE; otherwise j=k=0.
REQ-020 DRIVE (one cycle, j/k held): at the next edge, capture expected = HOLD:q_in, RESET:0, SET:1, TOGGLE:~q_in, using the pre-update q_in; set j=k=0; go to CHECK.
REQ-021 CHECK (one cycle): at the next edge, pulse done=1 for one cycle and set err if q_in != expected; if FIFO is non-empty, pop and go to DRIVE, otherwise go to IDLE.
REQ-022 Latency: a push at edge E0 into an empty, idle block gives j/k valid after E1, expected captured at E2, done high in the cycle after E3.
REQ-023 Steady-state throughput is one command per two cycles.
REQ-024 j and k shall never both be driven as a stale value: they are 00 in every cycle except DRIVE.
REQ-025 err_clr=1 clears err at the edge; a mismatch detected at the same edge takes priority and leaves err=1.
REQ-026 busy=0 only when the FSM is IDLE and count=0.

Reset
REQ-027 While reset=0: FSM=IDLE, count=0, pointers=0, j=0, k=0, done=0, err=0, expected=0, cmd_ready=1, busy=0.
REQ-028 Reset asserted mid-command (DRIVE or CHECK) shall discard all queued and in-flight commands, with no done pulse.
REQ-029 After reset release, the first push is accepted on the first rising edge at which reset=1.

Structure
REQ-030 Shared package jk_pkg shall hold the op encoding constants (OP_HOLD, OP_RESET, OP_SET, OP_TOGGLE) and the FSM state encoding.
REQ-031 The FIFO shall be a sub-module jk_cmd_fifo (DEPTH, 2-bit data, push/pop/full/empty/count); the FSM and checker reside in jk_cmd_sequencer.

Verification
REQ-032 Connect to the downstream JK flip-flop with q=0. Push SET, TOGGLE, TOGGLE, RESET back-to-back -> j/k sequence 10, 11, 11, 01; q sequence 1, 0, 1, 0; four done pulses two cycles apart; err=0.
REQ-033 Push DEPTH+1 commands in consecutive cycles while the FSM is stalled -> cmd_ready=0 after DEPTH pushes, the extra command is dropped, exactly DEPTH done pulses follow.
REQ-034 With the FIFO full, push and pop in the same cycle -> count stays DEPTH, cmd_ready stays 0, order preserved.
REQ-035 Force q_in=0 during CHECK of a SET -> err=1 and stays 1; then err_clr=1 coincident with another forced mismatch -> err remains 1; err_clr alone -> err=0.
REQ-036 Assert reset=0 during DRIVE with 3 commands queued -> j=k=0 immediately, busy=0, no done pulse; after release, a HOLD push gives done 3 edges later with j=k=0 throughout.
